mkio_rt_sequencer: RTL and testbench
====================================

Name: mkio_rt_sequencer

Overview:
- Remote-terminal message sequencer placed directly after mkio_receiver.
- Consumes received words (data_get/cd_get/done/parity_error), decodes command words, and qualifies them against the terminal address or broadcast.
- Forwards receive-data words to a subaddress buffer and times the status response.
- Requests status and transmit-data words from the downstream transmitter.

Parameters:
- GAP_TIMEOUT, 200, max clocks between consecutive rx_done pulses inside a message before abort.
- RESP_DELAY, 300, clocks from the qualifying rx_done to the tx_req pulse.
- CNT_W, 16, width of the shared gap/response counter; must hold max(GAP_TIMEOUT, RESP_DELAY).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rt_addr  in  5  own terminal address (31 is illegal; treat as broadcast-only).
- rx_data  in  16  received word (receiver data_get).
- rx_cd  in  1  1 = command/status sync, 0 = data sync (receiver cd_get).
- rx_done  in  1  1-cycle word-valid pulse (receiver done).
- rx_parity_error  in  1  parity flag, valid with rx_done.
- wr_en  out  1  1-cycle data-word write strobe.
- wr_data  out  16  data word.
- wr_subaddr  out  5  subaddress of the current message.
- wr_index  out  5  word index 0..31 within the message.
- tx_req  out  1  1-cycle request to send the status word (plus data, if any).
- tx_status  out  16  status word: [15:11] rt_addr, [10] message error, [4] broadcast received, others 0.
- tx_subaddr  out  5  subaddress/mode code for the transmit data source.
- tx_count  out  6  number of data words to follow the status word (0..32).
- msg_ok  out  1  1-cycle pulse: message completed successfully.
- msg_err  out  1  1-cycle pulse: message aborted.
- busy  out  1  1 when not in IDLE.

Behaviour:
- Command decode: [15:11] addr, [10] T/R (1 = transmit), [9:5] SA, [4:0] WC (0 means 32).
- Mode code: SA = 0 or 31. Data count is 1 if T/R=0 and WC[4]=1, otherwise 0. tx_count = 1 if T/R=1 and WC[4]=1.
- A word is valid only when rx_done=1 and rx_parity_error=0.
- A command is accepted if addr == rt_addr, or if addr == 31 (broadcast) and T/R=0.
- States:
  - IDLE: on an accepted command, latch SA/WC/T/R/bcast, clear the counter, and set the index to 0.
    - If data expected → RX_DATA.
    - Otherwise → RESP_WAIT.
    - Data words and non-accepted commands are ignored.
  - RX_DATA: on a valid data word, wr_en=1 the next cycle with wr_data/wr_subaddr/wr_index registered.
    - Index increments; the counter clears on each rx_done.
    - After the last expected word → RESP_WAIT.
  - RESP_WAIT: counter counts to RESP_DELAY-1.
    - Non-broadcast: then → RESPOND.
    - Broadcast: msg_ok pulses, set bcast_flag, → IDLE without tx_req.
  - RESPOND: single cycle. tx_req=1 with tx_status/tx_subaddr/tx_count stable, msg_ok=1, clear err_flag and bcast_flag, → IDLE.
- tx_status/tx_subaddr/tx_count: registered, held until the next tx_req.
- Errors (msg_err pulse, set sticky err_flag, → IDLE, no tx_req, no further wr_en):
  - rx_done with parity error in RX_DATA, or on an accepted command.
  - Counter reaching GAP_TIMEOUT in RX_DATA.
  - A data word arriving in RESP_WAIT (too many words).
- Superseding command: an accepted command arriving in RX_DATA or RESP_WAIT restarts decode from that command. It raises no msg_err and sets no err_flag.
- A non-accepted command in RX_DATA is treated as an error.
- tx_status[10] = err_flag and [4] = bcast_flag at the time of tx_req.
- Simultaneous events: rx_done takes priority over the timeout/delay terminal count in the same cycle.
- Reset (asynchronous, any state): state=IDLE, all outputs 0, counter/index/flags 0. Reset mid-message drops the message silently.

Test Plan:
- rt_addr=5. Command 0x2843, then data 0x1111, 0x2222, 0x3333 at 100-clock gaps.
  - Required: 3 wr_en pulses, wr_subaddr=2, wr_index 0/1/2.
  - Then tx_req exactly RESP_DELAY clocks after the 3rd rx_done, with tx_status=0x2800, tx_count=0, and msg_ok.
- Command 0x2C22 (transmit, SA 1, WC 2).
  - Required: no wr_en; tx_req after RESP_DELAY with tx_count=2, tx_subaddr=1, tx_status=0x2800.
- Errors:
  - Command 0x2843, data word 2 sent with rx_parity_error=1 → msg_err, no tx_req.
  - Next command 0x2C02 (mode: transmit status) → tx_req with tx_status=0x2C00 (bit 10 set), tx_count=0.
  - A following message → bit 10 clear.
- Broadcast 0xF841 with one data word 0xABCD.
  - Required: wr_en with wr_data=0xABCD, msg_ok, no tx_req.
  - Next 0x2C02 → tx_status=0x2810.
- Command 0x2843, one data word, then silence.
  - Required: msg_err at GAP_TIMEOUT clocks after that rx_done.
- Foreign command 0x3043 in IDLE → ignored, busy stays 0.
- Reset asserted mid-RX_DATA → all outputs 0 immediately.
- Command 0x2842, then command 0x2C22 after word 1 → no msg_err; tx_req with tx_count=2.

Source files
------------

// File: rtl/mkio_rt_sequencer_if.sv
// Receiver-side word stream in, buffer-write and transmitter-request signals out.
// The slave modport is the sequencer's view; the master modport is its environment.
interface mkio_rt_sequencer_if;
  logic [4:0]  rt_addr;
  logic [15:0] rx_data;
  logic        rx_cd;
  logic        rx_done;
  logic        rx_parity_error;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [4:0]  wr_subaddr;
  logic [4:0]  wr_index;
  logic        tx_req;
  logic [15:0] tx_status;
  logic [4:0]  tx_subaddr;
  logic [5:0]  tx_count;
  logic        msg_ok;
  logic        msg_err;
  logic        busy;

  modport master (
    output rt_addr, rx_data, rx_cd, rx_done, rx_parity_error,
    input  wr_en, wr_data, wr_subaddr, wr_index, tx_req, tx_status,
           tx_subaddr, tx_count, msg_ok, msg_err, busy
  );

  modport slave (
    input  rt_addr, rx_data, rx_cd, rx_done, rx_parity_error,
    output wr_en, wr_data, wr_subaddr, wr_index, tx_req, tx_status,
           tx_subaddr, tx_count, msg_ok, msg_err, busy
  );
endinterface

// File: rtl/mkio_rt_sequencer.sv
// Remote-terminal message sequencer: decodes and qualifies command words, forwards
// receive data to the subaddress buffer and times the status response request.
module mkio_rt_sequencer #(
  parameter int GAP_TIMEOUT = 200,
  parameter int RESP_DELAY  = 300,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mkio_rt_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RX_DATA, RESP_WAIT, RESPOND} state_e;

  // The counter reads 0 in the first clock after a word, so terminal counts sit two
  // below the limit: the registered pulse then lands exactly N clocks after the word.
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] RESP_TC = CNT_W'(RESP_DELAY - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         idx_q, idx_d;
  logic [5:0]         rx_n_q, rx_n_d;
  logic [5:0]         tx_n_q, tx_n_d;
  logic [4:0]         sa_q, sa_d;
  logic               bcast_msg_q, bcast_msg_d;
  logic               err_flag_q, err_flag_d;
  logic               bcast_flag_q, bcast_flag_d;
  logic               wr_en_q, wr_en_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic [4:0]         wr_subaddr_q, wr_subaddr_d;
  logic [4:0]         wr_index_q, wr_index_d;
  logic [15:0]        tx_status_q, tx_status_d;
  logic [4:0]         tx_subaddr_q, tx_subaddr_d;
  logic [5:0]         tx_count_q, tx_count_d;
  logic               msg_ok_q, msg_ok_d;
  logic               msg_err_q, msg_err_d;

  // Command-word decode of whatever is on rx_data.
  logic [4:0] cmd_addr, cmd_sa, cmd_wc;
  logic       cmd_tr, cmd_mode, cmd_accept;
  logic [5:0] cmd_words, cmd_rx_n, cmd_tx_n;
  logic       word_ok, fail;

  always_comb begin
    cmd_addr   = bus.rx_data[15:11];
    cmd_tr     = bus.rx_data[10];
    cmd_sa     = bus.rx_data[9:5];
    cmd_wc     = bus.rx_data[4:0];
    cmd_mode   = (cmd_sa == 5'd0) || (cmd_sa == 5'd31);
    cmd_words  = (cmd_wc == 5'd0) ? 6'd32 : {1'b0, cmd_wc};
    cmd_rx_n   = cmd_tr   ? 6'd0 : (cmd_mode ? {5'd0, cmd_wc[4]} : cmd_words);
    cmd_tx_n   = !cmd_tr  ? 6'd0 : (cmd_mode ? {5'd0, cmd_wc[4]} : cmd_words);
    // Address 31 can never be the terminal's own address, only broadcast.
    cmd_accept = bus.rx_cd &&
                 (((cmd_addr == bus.rt_addr) && (bus.rt_addr != 5'd31)) ||
                  ((cmd_addr == 5'd31) && !cmd_tr));
    word_ok    = bus.rx_done && !bus.rx_parity_error;
  end

  // NOTE: every variable gets a default at the top so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    rx_n_d       = rx_n_q;
    tx_n_d       = tx_n_q;
    sa_d         = sa_q;
    bcast_msg_d  = bcast_msg_q;
    err_flag_d   = err_flag_q;
    bcast_flag_d = bcast_flag_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_subaddr_d = wr_subaddr_q;
    wr_index_d   = wr_index_q;
    tx_status_d  = tx_status_q;
    tx_subaddr_d = tx_subaddr_q;
    tx_count_d   = tx_count_q;
    msg_ok_d     = 1'b0;
    msg_err_d    = 1'b0;
    fail         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_done && bus.rx_parity_error && cmd_accept) fail = 1'b1;
      end
      RX_DATA: begin
        if (bus.rx_done) begin
          cnt_d = '0;
          if (bus.rx_parity_error) begin
            fail = 1'b1;
          end else if (!bus.rx_cd) begin
            wr_en_d      = 1'b1;
            wr_data_d    = bus.rx_data;
            wr_subaddr_d = sa_q;
            wr_index_d   = idx_q[4:0];
            idx_d        = idx_q + 6'd1;
            if (idx_q + 6'd1 == rx_n_q) state_d = RESP_WAIT;
          end else if (!cmd_accept) begin
            fail = 1'b1;
          end
        end else if (cnt_q == GAP_TC) begin
          fail = 1'b1;
        end
      end
      RESP_WAIT: begin
        // Only words that matter here pre-empt the delay terminal count.
        if (bus.rx_done && (!bus.rx_cd || cmd_accept)) begin
          if (!bus.rx_cd || bus.rx_parity_error) fail = 1'b1;
        end else if (cnt_q == RESP_TC) begin
          msg_ok_d = 1'b1;
          if (bcast_msg_q) begin
            bcast_flag_d = 1'b1;
            state_d      = IDLE;
          end else begin
            tx_status_d  = {bus.rt_addr, err_flag_q, 5'd0, bcast_flag_q, 4'd0};
            tx_subaddr_d = sa_q;
            tx_count_d   = tx_n_q;
            state_d      = RESPOND;
          end
        end
      end
      RESPOND: begin
        err_flag_d   = 1'b0;
        bcast_flag_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      msg_err_d  = 1'b1;
      err_flag_d = 1'b1;
      state_d    = IDLE;
    end else if (word_ok && cmd_accept) begin
      // A fresh accepted command (re)starts decode, superseding any message in flight.
      sa_d        = cmd_sa;
      bcast_msg_d = (cmd_addr == 5'd31);
      rx_n_d      = cmd_rx_n;
      tx_n_d      = cmd_tx_n;
      idx_d       = '0;
      cnt_d       = '0;
      state_d     = (cmd_rx_n != 6'd0) ? RX_DATA : RESP_WAIT;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      rx_n_q       <= '0;
      tx_n_q       <= '0;
      sa_q         <= '0;
      bcast_msg_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      bcast_flag_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_subaddr_q <= '0;
      wr_index_q   <= '0;
      tx_status_q  <= '0;
      tx_subaddr_q <= '0;
      tx_count_q   <= '0;
      msg_ok_q     <= 1'b0;
      msg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rx_n_q       <= rx_n_d;
      tx_n_q       <= tx_n_d;
      sa_q         <= sa_d;
      bcast_msg_q  <= bcast_msg_d;
      err_flag_q   <= err_flag_d;
      bcast_flag_q <= bcast_flag_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_subaddr_q <= wr_subaddr_d;
      wr_index_q   <= wr_index_d;
      tx_status_q  <= tx_status_d;
      tx_subaddr_q <= tx_subaddr_d;
      tx_count_q   <= tx_count_d;
      msg_ok_q     <= msg_ok_d;
      msg_err_q    <= msg_err_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_subaddr = wr_subaddr_q;
  assign bus.wr_index   = wr_index_q;
  assign bus.tx_req     = (state_q == RESPOND);
  assign bus.tx_status  = tx_status_q;
  assign bus.tx_subaddr = tx_subaddr_q;
  assign bus.tx_count   = tx_count_q;
  assign bus.msg_ok     = msg_ok_q;
  assign bus.msg_err    = msg_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mkio_rt_sequencer.sv
// Directed plus randomized bench for mkio_rt_sequencer; expectations come from a
// message-level model of the command word rules and the status/flag bookkeeping.
module tb_mkio_rt_sequencer;
  localparam int GAP = 200;
  localparam int RD  = 300;
  localparam logic [4:0] RT = 5'd5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mkio_rt_sequencer_if bus_if ();

  mkio_rt_sequencer #(.GAP_TIMEOUT(GAP), .RESP_DELAY(RD), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] data; logic [4:0] sa; logic [4:0] idx; } wr_t;
  typedef struct { logic [15:0] status; logic [4:0] sa; logic [5:0] count; int at; } tx_t;

  wr_t         wr_q[$];
  tx_t         tx_q[$];
  logic [15:0] data_q[$];
  int          ok_n, err_n, err_at, done_at;
  logic        err_m, bcast_m;

  // Event monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.wr_en) wr_q.push_back('{bus_if.wr_data, bus_if.wr_subaddr, bus_if.wr_index});
      if (bus_if.tx_req) tx_q.push_back('{bus_if.tx_status, bus_if.tx_subaddr, bus_if.tx_count, cyc});
      if (bus_if.msg_ok) ok_n++;
      if (bus_if.msg_err) begin
        err_n++;
        err_at = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    tx_q.delete();
    ok_n   = 0;
    err_n  = 0;
    err_at = -1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one received word for one clock; called at a falling edge.
  task automatic pulse(input logic [15:0] w, input logic cd, input logic pe);
    bus_if.rx_data         = w;
    bus_if.rx_cd           = cd;
    bus_if.rx_parity_error = pe;
    bus_if.rx_done         = 1'b1;
    done_at                = cyc;
    @(negedge clk);
    bus_if.rx_done         = 1'b0;
    bus_if.rx_parity_error = 1'b0;
  endtask

  function automatic int words_of(input logic [15:0] cmd, input bit want_tx);
    logic [4:0] sa, wc;
    bit tr, mode;
    int n;
    tr   = cmd[10];
    sa   = cmd[9:5];
    wc   = cmd[4:0];
    mode = (sa == 0) || (sa == 31);
    n    = mode ? ((wc >= 16) ? 1 : 0) : ((wc == 0) ? 32 : int'(wc));
    return (tr == want_tx) ? n : 0;
  endfunction

  function automatic logic [15:0] status_m();
    return (16'(RT) << 11) | (err_m ? 16'h0400 : 16'h0) | (bcast_m ? 16'h0010 : 16'h0);
  endfunction

  // A well-formed message: command, then data_q words `spacing` clocks apart.
  task automatic run_good(input string tag, input logic [15:0] cmd, input int spacing);
    int last;
    bit bc;
    logic [4:0] sa;
    bc = (cmd[15:11] == 5'd31);
    sa = cmd[9:5];
    clear_mon();
    pulse(cmd, 1'b1, 1'b0);
    last = done_at;
    foreach (data_q[i]) begin
      gap(spacing - 1);
      pulse(data_q[i], 1'b0, 1'b0);
      last = done_at;
    end
    gap(RD + 4);
    check({tag, " wr_count"}, 64'(wr_q.size()), 64'(words_of(cmd, 1'b0)));
    foreach (wr_q[i]) begin
      if (i < data_q.size()) begin
        check({tag, " wr_data"}, 64'(wr_q[i].data), 64'(data_q[i]));
        check({tag, " wr_subaddr"}, 64'(wr_q[i].sa), 64'(sa));
        check({tag, " wr_index"}, 64'(wr_q[i].idx), 64'(i));
      end
    end
    check({tag, " msg_err"}, 64'(err_n), 64'd0);
    check({tag, " msg_ok"}, 64'(ok_n), 64'd1);
    if (bc) begin
      check({tag, " tx_req"}, 64'(tx_q.size()), 64'd0);
      bcast_m = 1'b1;
    end else begin
      check({tag, " tx_req"}, 64'(tx_q.size()), 64'd1);
      if (tx_q.size() > 0) begin
        check({tag, " tx_status"}, 64'(tx_q[0].status), 64'(status_m()));
        check({tag, " tx_subaddr"}, 64'(tx_q[0].sa), 64'(sa));
        check({tag, " tx_count"}, 64'(tx_q[0].count), 64'(words_of(cmd, 1'b1)));
        check({tag, " tx_time"}, 64'(tx_q[0].at), 64'(last + RD));
      end
      err_m   = 1'b0;
      bcast_m = 1'b0;
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {6'd0, bus_if.wr_en, bus_if.wr_data, bus_if.wr_subaddr, bus_if.wr_index,
            bus_if.tx_req, bus_if.tx_status, bus_if.tx_subaddr, bus_if.tx_count,
            bus_if.msg_ok, bus_if.msg_err, bus_if.busy};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cmd;
    int n, sp;
    reset                  = 1'b1;
    bus_if.rt_addr         = RT;
    bus_if.rx_data         = '0;
    bus_if.rx_cd           = 1'b0;
    bus_if.rx_done         = 1'b0;
    bus_if.rx_parity_error = 1'b0;
    err_m   = 1'b0;
    bcast_m = 1'b0;
    clear_mon();
    gap(3);
    check("reset outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    gap(2);

    // Receive three words to SA 2 at 100-clock spacing.
    data_q = '{16'h1111, 16'h2222, 16'h3333};
    run_good("rx3", 16'h2843, 100);

    // Transmit SA 1, two words.
    data_q.delete();
    run_good("tx2", 16'h2C22, 100);

    // Parity error on the second data word.
    clear_mon();
    pulse(16'h2843, 1'b1, 1'b0);
    gap(99);
    pulse(16'h1111, 1'b0, 1'b0);
    gap(99);
    pulse(16'h2222, 1'b0, 1'b1);
    n = done_at;
    gap(RD + 4);
    check("parity msg_err", 64'(err_n), 64'd1);
    check("parity err_time", 64'(err_at), 64'(n + 1));
    check("parity wr_count", 64'(wr_q.size()), 64'd1);
    check("parity tx_req", 64'(tx_q.size()), 64'd0);
    err_m = 1'b1;
    data_q.delete();
    run_good("status after err", 16'h2C02, 10);
    run_good("status cleared", 16'h2C02, 10);

    // Broadcast receive, then transmit-status shows the broadcast bit.
    data_q = '{16'hABCD};
    run_good("bcast", 16'hF841, 20);
    data_q.delete();
    run_good("status after bcast", 16'h2C02, 10);

    // Gap timeout after one of three data words.
    clear_mon();
    pulse(16'h2843, 1'b1, 1'b0);
    gap(19);
    pulse(16'h1111, 1'b0, 1'b0);
    n = done_at;
    gap(GAP + 5);
    check("timeout msg_err", 64'(err_n), 64'd1);
    check("timeout err_time", 64'(err_at), 64'(n + GAP));
    check("timeout tx_req", 64'(tx_q.size()), 64'd0);
    check("timeout busy", 64'(bus_if.busy), 64'd0);
    err_m = 1'b1;

    // Foreign address is ignored.
    clear_mon();
    pulse(16'h3043, 1'b1, 1'b0);
    check("foreign busy", 64'(bus_if.busy), 64'd0);
    gap(RD + 4);
    check("foreign events", 64'(tx_q.size() + wr_q.size() + ok_n + err_n), 64'd0);

    // Reset in the middle of a receive message.
    pulse(16'h2843, 1'b1, 1'b0);
    gap(9);
    pulse(16'h1111, 1'b0, 1'b0);
    check("pre-reset wr_en", 64'(bus_if.wr_en), 64'd1);
    reset = 1'b1;
    #1;
    check("mid-msg reset outputs", all_outputs(), 64'd0);
    gap(2);
    reset   = 1'b0;
    err_m   = 1'b0;
    bcast_m = 1'b0;
    gap(2);
    data_q.delete();
    run_good("status after reset", 16'h2C02, 10);

    // Superseding command after the first data word.
    clear_mon();
    pulse(16'h2842, 1'b1, 1'b0);
    gap(49);
    pulse(16'h1111, 1'b0, 1'b0);
    gap(49);
    pulse(16'h2C22, 1'b1, 1'b0);
    n = done_at;
    gap(RD + 4);
    check("supersede msg_err", 64'(err_n), 64'd0);
    check("supersede wr_count", 64'(wr_q.size()), 64'd1);
    check("supersede tx_req", 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) begin
      check("supersede tx_count", 64'(tx_q[0].count), 64'd2);
      check("supersede tx_subaddr", 64'(tx_q[0].sa), 64'd1);
      check("supersede tx_time", 64'(tx_q[0].at), 64'(n + RD));
      check("supersede tx_status", 64'(tx_q[0].status), 64'(status_m()));
    end
    err_m   = 1'b0;
    bcast_m = 1'b0;

    // Randomized well-formed messages, including mode codes and broadcasts.
    for (int k = 0; k < 12; k++) begin
      cmd[10]    = 1'($urandom_range(0, 1));
      cmd[15:11] = (!cmd[10] && $urandom_range(0, 3) == 0) ? 5'd31 : RT;
      cmd[9:5]   = 5'($urandom_range(0, 31));
      cmd[4:0]   = 5'($urandom_range(0, 31));
      sp         = $urandom_range(2, 12);
      data_q.delete();
      for (int i = 0; i < words_of(cmd, 1'b0); i++) data_q.push_back(16'($urandom));
      run_good($sformatf("rand%0d", k), cmd, sp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
